split_mux_2d_vld: RTL

SPLIT_MUX_2D_VLD -- requirements
Module: split_mux_2d_vld

---
 rtl/split_mux_2d_vld.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/split_mux_2d_vld.sv
// Two-level one-hot mux: per-group OR-reduce, then OR across groups, with select checking and a saturating error count.
// Latency 2 - SKIP_DFF_0 - SKIP_DFF_1 cycles, one beat per cycle; no backpressure (din_vld is never stalled).
module split_mux_2d_vld #(
   parameter int WIDTH      = 32,
   parameter int CNT        = 31,
   parameter int GROUP_SIZE = 8,
   parameter int SKIP_DFF_0 = 0,
   parameter int SKIP_DFF_1 = 0,
   parameter int HOLD       = 0,
   parameter int ERR_CNT_W  = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [CNT-1:0][WIDTH-1:0]  din,
   input  logic [CNT-1:0]             sel,
   input  logic                       din_vld,
   output logic [WIDTH-1:0]           dout,
   output logic                       dout_vld,
   output logic                       sel_err,
   output logic [ERR_CNT_W-1:0]       err_cnt
);

   localparam int NGRP  = (CNT + GROUP_SIZE - 1) / GROUP_SIZE;
   localparam int NLANE = NGRP * GROUP_SIZE;

   logic [NLANE-1:0][WIDTH-1:0] din_pad;
   logic [NLANE-1:0]            sel_pad;
   logic [NGRP-1:0][WIDTH-1:0]  gdata_d;
   logic [NGRP-1:0]             gany_d;
   logic [NGRP-1:0]             gmulti_d;

   // Zero-padding the last group keeps absent lanes out of both data and select checks.
   always_comb begin
      din_pad          = '0;
      sel_pad          = '0;
      din_pad[CNT-1:0] = din;
      sel_pad[CNT-1:0] = sel;
   end

   always_comb begin
      gdata_d  = '0;
      gany_d   = '0;
      gmulti_d = '0;
      for (int g = 0; g < NGRP; g++) begin
         for (int i = 0; i < GROUP_SIZE; i++) begin
            gdata_d[g] = gdata_d[g] | (din_pad[g*GROUP_SIZE+i] & {WIDTH{sel_pad[g*GROUP_SIZE+i]}});
         end
         gany_d[g]   = |sel_pad[g*GROUP_SIZE +: GROUP_SIZE];
         gmulti_d[g] = !$onehot0(sel_pad[g*GROUP_SIZE +: GROUP_SIZE]);
      end
   end

   logic [NGRP-1:0][WIDTH-1:0] s1_data;
   logic [NGRP-1:0]            s1_any;
   logic [NGRP-1:0]            s1_multi;
   logic                       s1_vld;

   generate
      if (SKIP_DFF_0 != 0) begin : g_s0_comb
         // Bypassed stages are forced low under reset so outputs read 0 while rst_n=0.
         always_comb begin
            s1_data  = '0;
            s1_any   = '0;
            s1_multi = '0;
            s1_vld   = 1'b0;
            if (rst_n) begin
               s1_data  = gdata_d;
               s1_any   = gany_d;
               s1_multi = gmulti_d;
               s1_vld   = din_vld;
            end
         end
      end else begin : g_s0_reg
         logic [NGRP-1:0][WIDTH-1:0] gdata_q;
         logic [NGRP-1:0]            gany_q;
         logic [NGRP-1:0]            gmulti_q;
         logic                       vld_q;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               gdata_q  <= '0;
               gany_q   <= '0;
               gmulti_q <= '0;
               vld_q    <= 1'b0;
            end else begin
               gany_q   <= gany_d;
               gmulti_q <= gmulti_d;
               vld_q    <= din_vld;
               if (HOLD == 0 || din_vld) gdata_q <= gdata_d;
            end
         end
         assign s1_data  = gdata_q;
         assign s1_any   = gany_q;
         assign s1_multi = gmulti_q;
         assign s1_vld   = vld_q;
      end
   endgenerate

   logic [WIDTH-1:0] dout_d;
   logic             sel_err_d;

   always_comb begin
      dout_d = '0;
      for (int g = 0; g < NGRP; g++) dout_d = dout_d | s1_data[g];
      sel_err_d = s1_vld & (!$onehot(s1_any) | (|s1_multi));
   end

   generate
      if (SKIP_DFF_1 != 0) begin : g_s1_comb
         always_comb begin
            dout     = '0;
            dout_vld = 1'b0;
            sel_err  = 1'b0;
            if (rst_n) begin
               dout     = dout_d;
               dout_vld = s1_vld;
               sel_err  = sel_err_d;
            end
         end
      end else begin : g_s1_reg
         logic [WIDTH-1:0] dout_q;
         logic             dout_vld_q;
         logic             sel_err_q;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               dout_q     <= '0;
               dout_vld_q <= 1'b0;
               sel_err_q  <= 1'b0;
            end else begin
               dout_vld_q <= s1_vld;
               sel_err_q  <= sel_err_d;
               if (HOLD == 0 || s1_vld) dout_q <= dout_d;
            end
         end
         assign dout     = dout_q;
         assign dout_vld = dout_vld_q;
         assign sel_err  = sel_err_q;
      end
   endgenerate

   logic [ERR_CNT_W-1:0] err_cnt_d;
   logic [ERR_CNT_W-1:0] err_cnt_q;

   always_comb begin
      err_cnt_d = err_cnt_q;
      if (dout_vld && sel_err && err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) err_cnt_q <= '0;
      else        err_cnt_q <= err_cnt_d;
   end

   assign err_cnt = err_cnt_q;

endmodule
